// File: rtl/hybrid_buffer_drain_if.sv
// rtl/hybrid_buffer_drain_if.sv - slot request, FIFO head and output stream bundle for the drain engine
interface hybrid_buffer_drain_if #(
  parameter int NUM_SLOTS     = 16,
  parameter int READ_WIDTH    = 32,
  parameter int READ_DEPTH    = 1024,
  parameter int SLOT_ID_WIDTH = 20,
  parameter int LEN_W         = $clog2(READ_DEPTH) + 1,
  parameter int SLOT_W        = $clog2(NUM_SLOTS)
);
  logic [NUM_SLOTS-1:0]                    drain_req;
  logic [NUM_SLOTS-1:0][LEN_W-1:0]         drain_len;
  logic [NUM_SLOTS-1:0][SLOT_ID_WIDTH-1:0] slot_node_id;
  logic [NUM_SLOTS-1:0]                    buf_valid;
  logic [NUM_SLOTS-1:0][READ_WIDTH-1:0]    buf_feature;
  logic [NUM_SLOTS-1:0]                    pop;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [READ_WIDTH-1:0]                   out_data;
  logic [SLOT_ID_WIDTH-1:0]                out_node_id;
  logic                                    out_last;
  logic [NUM_SLOTS-1:0]                    drain_active;
  logic                                    drain_done;
  logic [SLOT_W-1:0]                       drain_done_slot;

  // master is the drain engine; slave is the buffer owner plus the downstream consumer
  modport master (
    input  drain_req, drain_len, slot_node_id, buf_valid, buf_feature, out_ready,
    output pop, out_valid, out_data, out_node_id, out_last,
    output drain_active, drain_done, drain_done_slot
  );

  modport slave (
    output drain_req, drain_len, slot_node_id, buf_valid, buf_feature, out_ready,
    input  pop, out_valid, out_data, out_node_id, out_last,
    input  drain_active, drain_done, drain_done_slot
  );
endinterface

// File: rtl/hybrid_buffer_drain.sv
// rtl/hybrid_buffer_drain.sv - round-robin slot drain engine feeding a registered valid/ready stream
module hybrid_buffer_drain #(
  parameter int NUM_SLOTS     = 16,
  parameter int READ_WIDTH    = 32,
  parameter int READ_DEPTH    = 1024,
  parameter int SLOT_ID_WIDTH = 20
) (
  input  logic                    i_core_clk,
  input  logic                    i_resetn,
  hybrid_buffer_drain_if.master   io_drain
);
  localparam int LEN_W  = $clog2(READ_DEPTH) + 1;
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SLOT_W-1:0]        r_rr_ptr;
  logic [SLOT_W-1:0]        r_slot;
  logic [LEN_W-1:0]         r_remaining;
  logic [SLOT_ID_WIDTH-1:0] r_node_id;
  logic [NUM_SLOTS-1:0]     r_drain_active;
  logic                     r_out_valid;
  logic [READ_WIDTH-1:0]    r_out_data;
  logic [SLOT_ID_WIDTH-1:0] r_out_node_id;
  logic                     r_out_last;

  logic                     w_grant_vld;
  logic [SLOT_W-1:0]        w_grant_idx;
  logic [SLOT_W:0]          w_cand;
  logic [SLOT_W-1:0]        w_rr_nxt;
  logic                     w_grant;
  logic                     w_pop_fire;
  logic                     w_out_accept;
  logic                     w_done;

  // Scan from the far end toward the RR pointer so the nearest requester is the last one written.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      w_cand = {1'b0, r_rr_ptr} + (SLOT_W+1)'(i);
      if (w_cand >= (SLOT_W+1)'(NUM_SLOTS)) begin
        w_cand = w_cand - (SLOT_W+1)'(NUM_SLOTS);
      end
      if (io_drain.drain_req[w_cand[SLOT_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand[SLOT_W-1:0];
      end
    end
  end

  assign w_rr_nxt     = (w_grant_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : w_grant_idx + 1'b1;
  assign w_grant      = (r_state == ST_IDLE) && w_grant_vld;
  assign w_out_accept = r_out_valid && io_drain.out_ready;

  // A pop may refill the output register in the same cycle the old beat is accepted.
  assign w_pop_fire = (r_state == ST_DRAIN) && (r_remaining != '0) &&
                      io_drain.buf_valid[r_slot] &&
                      (!r_out_valid || io_drain.out_ready);

  always_ff @(posedge i_core_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = (io_drain.drain_len[w_grant_idx] == '0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop_fire && (r_remaining == LEN_W'(1))) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_out_accept) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant context is latched once so later drain_len / node ID edits cannot disturb the drain.
  always_ff @(posedge i_core_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_rr_ptr       <= '0;
      r_slot         <= '0;
      r_remaining    <= '0;
      r_node_id      <= '0;
      r_drain_active <= '0;
    end else begin
      if (w_grant) begin
        r_slot         <= w_grant_idx;
        r_remaining    <= io_drain.drain_len[w_grant_idx];
        r_node_id      <= io_drain.slot_node_id[w_grant_idx];
        r_rr_ptr       <= w_rr_nxt;
        r_drain_active <= NUM_SLOTS'(1) << w_grant_idx;
      end else if (r_state == ST_DONE) begin
        r_drain_active <= '0;
      end
      if (w_pop_fire) begin
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  always_ff @(posedge i_core_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_node_id <= '0;
      r_out_last    <= 1'b0;
    end else begin
      if (w_pop_fire) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= io_drain.buf_feature[r_slot];
        r_out_node_id <= r_node_id;
        r_out_last    <= (r_remaining == LEN_W'(1));
      end else if (w_out_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_drain.pop             = w_pop_fire ? (NUM_SLOTS'(1) << r_slot) : '0;
  assign io_drain.out_valid       = r_out_valid;
  assign io_drain.out_data        = r_out_data;
  assign io_drain.out_node_id     = r_out_node_id;
  assign io_drain.out_last        = r_out_last;
  assign io_drain.drain_active    = r_drain_active;
  assign io_drain.drain_done      = w_done;
  assign io_drain.drain_done_slot = w_done ? r_slot : '0;
endmodule

// File: tb/tb_hybrid_buffer_drain.sv
// tb/tb_hybrid_buffer_drain.sv - scoreboard bench for hybrid_buffer_drain
module tb_hybrid_buffer_drain;
  localparam int NUM_SLOTS     = 16;
  localparam int READ_WIDTH    = 32;
  localparam int READ_DEPTH    = 1024;
  localparam int SLOT_ID_WIDTH = 20;
  localparam int LEN_W         = $clog2(READ_DEPTH) + 1;

  typedef struct {
    logic [READ_WIDTH-1:0]    data;
    logic [SLOT_ID_WIDTH-1:0] node;
    bit                       last;
  } beat_t;

  logic core_clk = 1'b0;
  logic resetn   = 1'b0;
  always #5 core_clk = ~core_clk;

  hybrid_buffer_drain_if #(
    .NUM_SLOTS(NUM_SLOTS), .READ_WIDTH(READ_WIDTH),
    .READ_DEPTH(READ_DEPTH), .SLOT_ID_WIDTH(SLOT_ID_WIDTH)
  ) drain_if ();

  hybrid_buffer_drain #(
    .NUM_SLOTS(NUM_SLOTS), .READ_WIDTH(READ_WIDTH),
    .READ_DEPTH(READ_DEPTH), .SLOT_ID_WIDTH(SLOT_ID_WIDTH)
  ) dut (
    .i_core_clk(core_clk),
    .i_resetn  (resetn),
    .io_drain  (drain_if)
  );

  beat_t                 sb_beats[$];
  int                    sb_done[$];
  logic [READ_WIDTH-1:0] fifo[NUM_SLOTS][$];
  bit                    gate[NUM_SLOTS];
  bit                    rand_gate;
  bit                    rand_ready;
  bit                    ready_manual;
  int                    n_vec;
  int                    n_err;
  int                    cyc;
  bit                    m_idle = 1'b1;
  int                    m_slot;
  int                    m_rr;
  int                    done_log[$];
  int                    pop_cyc[$];
  int                    n_beats;
  int                    done_cyc;
  bit                    auto_release;
  int                    rel_idx;

  task automatic chk_eq(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge core_clk);
    cyc = cyc + 1;
  end

  initial begin : drv
    bit g;
    drain_if.buf_valid   = '0;
    drain_if.buf_feature = '0;
    drain_if.out_ready   = 1'b1;
    forever begin
      @(posedge core_clk);
      #2;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        g = rand_gate ? ($urandom_range(0, 3) != 0) : gate[s];
        drain_if.buf_valid[s]   = (fifo[s].size() > 0) && g;
        drain_if.buf_feature[s] = (fifo[s].size() > 0) ? fifo[s][0] : READ_WIDTH'($urandom);
      end
      drain_if.out_ready = rand_ready ? ($urandom_range(0, 9) < 7) : ready_manual;
    end
  end

  // Monitor, scoreboard and reference model: all sampled mid-cycle at the falling edge.
  initial begin : mon
    beat_t                    b;
    bit                       hold_v;
    logic [READ_WIDTH-1:0]    hold_d;
    logic [SLOT_ID_WIDTH-1:0] hold_n;
    bit                       hold_l;
    logic [NUM_SLOTS-1:0]     exp_act;
    int                       len;
    int                       s;
    hold_v = 1'b0;
    forever begin
      @(negedge core_clk);
      if (!resetn) begin
        sb_beats.delete();
        sb_done.delete();
        m_idle = 1'b1;
        m_rr   = 0;
        hold_v = 1'b0;
        continue;
      end
      exp_act = m_idle ? '0 : (NUM_SLOTS'(1) << m_slot);
      chk_eq("drain_active", drain_if.drain_active, exp_act);
      if (hold_v) begin
        chk_eq("stall_valid", drain_if.out_valid, 1);
        chk_eq("stall_data", drain_if.out_data, hold_d);
        chk_eq("stall_node", drain_if.out_node_id, hold_n);
        chk_eq("stall_last", drain_if.out_last, hold_l);
      end
      hold_v = drain_if.out_valid && !drain_if.out_ready;
      hold_d = drain_if.out_data;
      hold_n = drain_if.out_node_id;
      hold_l = drain_if.out_last;
      if (drain_if.pop != '0) begin
        chk_eq("pop_target", drain_if.pop, exp_act & drain_if.buf_valid);
        if (hold_v) chk_eq("pop_while_stalled", drain_if.pop, 0);
        for (int k = 0; k < NUM_SLOTS; k++) begin
          if (drain_if.pop[k] && fifo[k].size() > 0) void'(fifo[k].pop_front());
        end
        pop_cyc.push_back(cyc);
      end
      if (drain_if.out_valid && drain_if.out_ready) begin
        n_beats++;
        chk_eq("beat_expected", sb_beats.size() != 0, 1);
        if (sb_beats.size() != 0) begin
          b = sb_beats.pop_front();
          chk_eq("beat_data", drain_if.out_data, b.data);
          chk_eq("beat_node", drain_if.out_node_id, b.node);
          chk_eq("beat_last", drain_if.out_last, b.last);
        end
      end
      if (drain_if.drain_done) begin
        done_log.push_back(int'(drain_if.drain_done_slot));
        done_cyc = cyc;
        chk_eq("done_expected", sb_done.size() != 0, 1);
        if (sb_done.size() != 0) chk_eq("done_slot", drain_if.drain_done_slot, sb_done.pop_front());
        chk_eq("done_beats_left", sb_beats.size(), 0);
      end
      if (m_idle) begin
        if (drain_if.drain_req != '0) begin
          s = m_rr;
          while (!drain_if.drain_req[s]) s = (s + 1) % NUM_SLOTS;
          m_slot = s;
          m_rr   = (s + 1) % NUM_SLOTS;
          m_idle = 1'b0;
          len    = int'(drain_if.drain_len[s]);
          for (int k = 0; k < len; k++) begin
            b.data = (k < fifo[s].size()) ? fifo[s][k] : 'x;
            b.node = drain_if.slot_node_id[s];
            b.last = (k == len - 1);
            sb_beats.push_back(b);
          end
          sb_done.push_back(s);
        end
      end else if (drain_if.drain_done) begin
        m_idle = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge core_clk);
    #1;
    while (rel_idx < done_log.size()) begin
      if (auto_release) drain_if.drain_req[done_log[rel_idx]] = 1'b0;
      rel_idx++;
    end
  endtask

  task automatic request(input int s, input int len);
    for (int k = 0; k < len; k++) fifo[s].push_back(READ_WIDTH'($urandom));
    drain_if.drain_len[s]    = LEN_W'(len);
    drain_if.slot_node_id[s] = SLOT_ID_WIDTH'($urandom);
    drain_if.drain_req[s]    = 1'b1;
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    int t;
    t = 0;
    while (done_log.size() < target && t < budget) begin
      step();
      t++;
    end
    chk_eq({name, "_done_seen"}, done_log.size() >= target, 1);
    step();
  endtask

  task automatic wait_cond_beats(input int target, input int budget, input string name);
    int t;
    t = 0;
    while (n_beats < target && t < budget) begin
      step();
      t++;
    end
    chk_eq({name, "_beat_seen"}, n_beats >= target, 1);
  endtask

  initial begin
    int base;
    int p0;
    int rc;
    int nb;
    int s;
    int t;
    int pat[5];
    drain_if.drain_req    = '0;
    drain_if.drain_len    = '0;
    drain_if.slot_node_id = '0;
    ready_manual = 1'b1;
    rand_gate    = 1'b0;
    rand_ready   = 1'b0;
    auto_release = 1'b1;
    for (int k = 0; k < NUM_SLOTS; k++) gate[k] = 1'b1;

    repeat (3) @(posedge core_clk);
    #1;
    chk_eq("rst_pop", drain_if.pop, 0);
    chk_eq("rst_out_valid", drain_if.out_valid, 0);
    chk_eq("rst_out_data", drain_if.out_data, 0);
    chk_eq("rst_out_node", drain_if.out_node_id, 0);
    chk_eq("rst_out_last", drain_if.out_last, 0);
    chk_eq("rst_active", drain_if.drain_active, 0);
    chk_eq("rst_done", drain_if.drain_done, 0);
    chk_eq("rst_done_slot", drain_if.drain_done_slot, 0);
    resetn = 1'b1;
    step();

    // single slot, full rate
    base = done_log.size();
    p0   = pop_cyc.size();
    request(3, 4);
    wait_dones(base + 1, 50, "single");
    chk_eq("single_pop_count", pop_cyc.size() - p0, 4);
    if (pop_cyc.size() >= p0 + 4) chk_eq("single_pop_span", pop_cyc[p0+3] - pop_cyc[p0], 3);
    chk_eq("single_done_slot", done_log[done_log.size()-1], 3);

    // round robin with held requests
    auto_release = 1'b0;
    base = done_log.size();
    for (int k = 0; k < 4; k++) fifo[0].push_back(READ_WIDTH'($urandom));
    for (int k = 0; k < 2; k++) fifo[1].push_back(READ_WIDTH'($urandom));
    for (int k = 0; k < 2; k++) fifo[3].push_back(READ_WIDTH'($urandom));
    for (int k = 0; k < 4; k++) begin
      if (k != 2) begin
        drain_if.drain_len[k]    = LEN_W'(2);
        drain_if.slot_node_id[k] = SLOT_ID_WIDTH'($urandom);
        drain_if.drain_req[k]    = 1'b1;
      end
    end
    t = 0;
    while (done_log.size() < base + 4 && t < 100) begin
      step();
      t++;
    end
    drain_if.drain_req = '0;
    chk_eq("rr_done_seen", done_log.size() >= base + 4, 1);
    if (done_log.size() >= base + 4) begin
      chk_eq("rr_grant0", done_log[base], 0);
      chk_eq("rr_grant1", done_log[base+1], 1);
      chk_eq("rr_grant2", done_log[base+2], 3);
      chk_eq("rr_grant3", done_log[base+3], 0);
    end
    step();
    step();
    auto_release = 1'b1;

    // backpressure pattern
    base = done_log.size();
    request(1, 3);
    t = 0;
    while (!drain_if.out_valid && t < 20) begin
      step();
      t++;
    end
    chk_eq("bp_first_valid", drain_if.out_valid, 1);
    pat = '{1, 0, 0, 1, 1};
    for (int k = 0; k < 5; k++) begin
      ready_manual = pat[k][0];
      step();
    end
    ready_manual = 1'b1;
    wait_dones(base + 1, 50, "bp");

    // empty FIFO stall
    base = done_log.size();
    p0   = pop_cyc.size();
    request(7, 2);
    t = 0;
    while (pop_cyc.size() == p0 && t < 20) begin
      step();
      t++;
    end
    gate[7] = 1'b0;
    nb = n_beats;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_eq("empty_no_pop", drain_if.pop, 0);
      chk_eq("empty_no_done", drain_if.drain_done, 0);
    end
    chk_eq("empty_one_beat", n_beats - nb, 1);
    gate[7] = 1'b1;
    wait_dones(base + 1, 50, "empty");
    chk_eq("empty_pops", pop_cyc.size() - p0, 2);

    // zero length
    base = done_log.size();
    nb   = n_beats;
    request(5, 0);
    rc = cyc;
    wait_dones(base + 1, 20, "zero");
    chk_eq("zero_latency_ok", (done_cyc - rc) <= 2, 1);
    chk_eq("zero_no_beats", n_beats - nb, 0);

    // reset during DRAIN, then pointer restarts at slot 0
    p0 = pop_cyc.size();
    request(6, 8);
    t = 0;
    while (pop_cyc.size() == p0 && t < 20) begin
      step();
      t++;
    end
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk_eq("mid_rst_pop", drain_if.pop, 0);
    chk_eq("mid_rst_valid", drain_if.out_valid, 0);
    chk_eq("mid_rst_data", drain_if.out_data, 0);
    chk_eq("mid_rst_last", drain_if.out_last, 0);
    chk_eq("mid_rst_active", drain_if.drain_active, 0);
    chk_eq("mid_rst_done", drain_if.drain_done, 0);
    drain_if.drain_req = '0;
    for (int k = 0; k < NUM_SLOTS; k++) fifo[k].delete();
    base = done_log.size();
    step();
    step();
    resetn = 1'b1;
    step();
    chk_eq("mid_rst_no_done", done_log.size(), base);
    request(10, 2);
    request(0, 2);
    wait_dones(base + 2, 60, "post_rst");
    if (done_log.size() >= base + 2) begin
      chk_eq("post_rst_first", done_log[base], 0);
      chk_eq("post_rst_second", done_log[base+1], 10);
    end

    // randomized traffic
    rand_gate  = 1'b1;
    rand_ready = 1'b1;
    for (int c = 0; c < 800; c++) begin
      step();
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, NUM_SLOTS - 1);
        if (!drain_if.drain_req[s] && fifo[s].size() == 0 && (m_idle || m_slot != s))
          request(s, $urandom_range(0, 6));
      end
      if (!m_idle && $urandom_range(0, 15) == 0) begin
        drain_if.drain_req[m_slot]    = 1'b0;
        drain_if.drain_len[m_slot]    = LEN_W'($urandom);
        drain_if.slot_node_id[m_slot] = SLOT_ID_WIDTH'($urandom);
      end
    end
    rand_gate    = 1'b0;
    rand_ready   = 1'b0;
    ready_manual = 1'b1;
    t = 0;
    while ((drain_if.drain_req != '0 || !m_idle || sb_beats.size() != 0) && t < 3000) begin
      step();
      t++;
    end
    step();
    chk_eq("rand_drained", drain_if.drain_req == '0 && m_idle, 1);
    chk_eq("rand_sb_beats_empty", sb_beats.size(), 0);
    chk_eq("rand_sb_done_empty", sb_done.size(), 0);
    nb = 0;
    for (int k = 0; k < NUM_SLOTS; k++) nb += fifo[k].size();
    chk_eq("rand_fifos_empty", nb, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
